// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op encoding, FSM states, default width.
package alu_seq_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_ASR = 3'b100,
        OP_LSR = 3'b101,
        OP_AND = 3'b110,
        OP_OR  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_t;

    function automatic logic is_iterative(input alu_op_t op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared MUL/DIV datapath: LSB-first shift-add multiply and restoring divide,
// one bit per cycle over WIDTH cycles. o_done/o_result expose the final iteration.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_op2;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_is_div;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [WIDTH-1:0] w_op2_nxt;

    // Next iteration value; a zero divisor never borrows, so the quotient fills with ones
    always_comb begin
        w_rem_sh = {r_acc, r_sh[WIDTH-1]};
        w_trial  = w_rem_sh - {1'b0, r_op2};
        if (r_is_div) begin
            w_op2_nxt = r_op2;
            if (!w_trial[WIDTH]) begin
                w_acc_nxt = w_trial[WIDTH-1:0];
                w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_rem_sh[WIDTH-1:0];
                w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = r_sh[0] ? (r_acc + r_op2) : r_acc;
            w_sh_nxt  = {1'b0, r_sh[WIDTH-1:1]};
            w_op2_nxt = {r_op2[WIDTH-2:0], 1'b0};
        end
    end

    assign o_done   = r_busy && (r_cnt == {CW{1'b0}});
    assign o_result = r_is_div ? w_sh_nxt : w_acc_nxt;

    // Load operands on start, then iterate until the counter expires
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_sh     <= {WIDTH{1'b0}};
            r_op2    <= {WIDTH{1'b0}};
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_is_div <= i_is_div;
            r_cnt    <= CW'(WIDTH - 1);
            r_acc    <= {WIDTH{1'b0}};
            r_sh     <= i_is_div ? i_a : i_b;
            r_op2    <= i_is_div ? i_b : i_a;
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_sh  <= w_sh_nxt;
            r_op2 <= w_op2_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == {CW{1'b0}}) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: IDLE/BUSY/DONE FSM, single-cycle ops, registered outputs.
// Optional ALU_SEQ_CV_EN adds carry (flagC) and signed-overflow (flagV) outputs.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             flagZ,
    output logic             flagN,
    output logic             div_zero
`ifdef ALU_SEQ_CV_EN
    ,
    output logic             flagC,
    output logic             flagV
`endif
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       r_state;
    alu_op_t          r_op;
    logic             r_b_zero;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_c;
    logic             r_z;
    logic             r_n;
    logic             r_dz;

    alu_op_t          w_op;
    logic [WIDTH-1:0] w_res;
    logic             w_start;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_res;

    assign w_op    = alu_op_t'(sel);
    assign w_start = r_in_ready && in_valid && is_iterative(w_op);

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_is_div (w_op == OP_DIV),
        .i_a      (A),
        .i_b      (B),
        .o_done   (w_iter_done),
        .o_result (w_iter_res)
    );

    // Single-cycle result
    always_comb begin
        case (w_op)
            OP_ADD:  w_res = A + B;
            OP_SUB:  w_res = A - B;
            OP_ASR:  w_res = WIDTH'($signed(A) >>> B[SHW-1:0]);
            OP_LSR:  w_res = A >> B[SHW-1:0];
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            default: w_res = {WIDTH{1'b0}};
        endcase
    end

`ifdef ALU_SEQ_CV_EN
    logic r_cf;
    logic r_vf;
    logic w_cf;
    logic w_vf;

    // Carry wraps the sum below A; SUB reports no-borrow; overflow flips the sign
    always_comb begin
        case (w_op)
            OP_ADD: begin
                w_cf = (w_res < A);
                w_vf = (A[WIDTH-1] == B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_cf = (A >= B);
                w_vf = (A[WIDTH-1] != B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            end
            default: begin
                w_cf = 1'b0;
                w_vf = 1'b0;
            end
        endcase
    end

    // Carry/overflow registered alongside C
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cf <= 1'b0;
            r_vf <= 1'b0;
        end else if (r_state == ST_IDLE && in_valid && !is_iterative(w_op)) begin
            r_cf <= w_cf;
            r_vf <= w_vf;
        end else if (r_state == ST_BUSY && w_iter_done) begin
            r_cf <= 1'b0;
            r_vf <= 1'b0;
        end
    end

    assign flagC = r_cf;
    assign flagV = r_vf;
`endif

    // Control FSM and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ADD;
            r_b_zero    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_c         <= {WIDTH{1'b0}};
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op       <= w_op;
                        r_b_zero   <= (B == {WIDTH{1'b0}});
                        r_in_ready <= 1'b0;
                        if (is_iterative(w_op)) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_c         <= w_res;
                            r_z         <= (w_res == {WIDTH{1'b0}});
                            r_n         <= w_res[WIDTH-1];
                            r_dz        <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_iter_done) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_c         <= w_iter_res;
                        r_z         <= (w_iter_res == {WIDTH{1'b0}});
                        r_n         <= w_iter_res[WIDTH-1];
                        r_dz        <= (r_op == OP_DIV) && r_b_zero;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign C         = r_c;
    assign flagZ     = r_z;
    assign flagN     = r_n;
    assign div_zero  = r_dz;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): directed cases plus random ops with backpressure.
// Checks flagC/flagV as well when ALU_SEQ_CV_EN is defined.
module tb_alu_seq;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] C;
    logic         flagZ;
    logic         flagN;
    logic         div_zero;
`ifdef ALU_SEQ_CV_EN
    logic         flagC;
    logic         flagV;
`endif

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .flagZ     (flagZ),
        .flagN     (flagN),
        .div_zero  (div_zero)
`ifdef ALU_SEQ_CV_EN
        ,
        .flagC     (flagC),
        .flagV     (flagV)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] c;
        logic         z;
        logic         n;
        logic         dz;
        logic         cf;
        logic         vf;
        int           t_acc;
        int           t_valid;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   bp_cnt = 0;
    bit   rand_bp = 1'b0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: plain arithmetic straight from the op definitions
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t         r;
        logic [63:0]  prod;
        longint       s;
        r.cf = 1'b0; r.vf = 1'b0; r.dz = 1'b0; r.t_acc = 0; r.t_valid = 0;
        case (op)
            3'd0: begin
                r.c  = a + b;
                r.cf = (33'(a) + 33'(b)) >= 33'h100000000;
                s    = longint'($signed(a)) + longint'($signed(b));
                r.vf = (s > SMAX) || (s < SMIN);
            end
            3'd1: begin
                r.c  = a - b;
                r.cf = (a >= b);
                s    = longint'($signed(a)) - longint'($signed(b));
                r.vf = (s > SMAX) || (s < SMIN);
            end
            3'd2: begin
                prod = 64'(a) * 64'(b);
                r.c  = prod[31:0];
            end
            3'd3: begin
                if (b == 32'h0) begin
                    r.c  = 32'hFFFFFFFF;
                    r.dz = 1'b1;
                end else begin
                    r.c = a / b;
                end
            end
            3'd4: r.c = $signed(a) >>> b[4:0];
            3'd5: r.c = a >> b[4:0];
            3'd6: r.c = a & b;
            3'd7: r.c = a | b;
            default: r.c = 32'h0;
        endcase
        r.z = (r.c == 32'h0);
        r.n = r.c[31];
        return r;
    endfunction

    // Present one op and hold in_valid until accepted; optionally expect its result
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input bit push);
        exp_t e;
        int   waited = 0;
        in_valid = 1'b1; A = a; B = b; sel = op;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'b0, in_ready}, 32'h1);
        end else begin
            if (push) begin
                e = model(a, b, op);
                e.t_acc   = cyc;
                e.t_valid = cyc + (((op == 3'd2) || (op == 3'd3)) ? (W + 1) : 1);
                q.push_back(e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] corners [4];
        corners = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return W'($urandom_range(0, 15));
            2: return corners[$urandom_range(0, 3)];
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    // Monitor: compares whatever the DUT presents against the head of the scoreboard
    initial begin
        exp_t e;
        bit   prev_v = 1'b0;
        bit   chk_idle = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v   = 1'b0;
                chk_idle = 1'b0;
            end else begin
                if (chk_idle) begin
                    check("idle_in_ready", {31'b0, in_ready}, 32'h1);
                    check("idle_out_valid", {31'b0, out_valid}, 32'h0);
                    chk_idle = 1'b0;
                end
                if (!out_valid && q.size() > 0 && cyc > q[0].t_acc && cyc < q[0].t_valid) begin
                    check("busy_in_ready", {31'b0, in_ready}, 32'h0);
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_valid", {31'b0, out_valid}, 32'h0);
                        out_ready = 1'b1;
                    end else begin
                        e = q[0];
                        if (!prev_v) check("latency", cyc, e.t_valid);
                        check("C", C, e.c);
                        check("flagZ", {31'b0, flagZ}, {31'b0, e.z});
                        check("flagN", {31'b0, flagN}, {31'b0, e.n});
                        check("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
`ifdef ALU_SEQ_CV_EN
                        check("flagC", {31'b0, flagC}, {31'b0, e.cf});
                        check("flagV", {31'b0, flagV}, {31'b0, e.vf});
`endif
                        check("done_in_ready", {31'b0, in_ready}, 32'h0);
                        if (bp_cnt > 0) begin
                            out_ready = 1'b0;
                            bp_cnt--;
                        end else begin
                            out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
                        end
                        if (out_ready) begin
                            void'(q.pop_front());
                            chk_idle = 1'b1;
                        end
                    end
                end else begin
                    out_ready = rand_bp ? ($urandom_range(0, 1) != 0) : 1'b1;
                end
                prev_v = out_valid;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0 || out_valid) check("drain_timeout", q.size(), 32'h0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        rst = 1'b1; in_valid = 1'b0; A = 32'h0; B = 32'h0; sel = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_C", C, 32'h0);
        check("rst_flags", {29'b0, flagZ, flagN, div_zero}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'hA, 32'h5, 3'd0, 1'b1);
        issue(32'hA, 32'hA, 3'd1, 1'b1);
        issue(32'hA, 32'h3, 3'd2, 1'b1);
        issue(32'hFFFFFFFF, 32'h2, 3'd2, 1'b1);
        issue(32'hF, 32'h3, 3'd3, 1'b1);
        issue(32'h7, 32'h0, 3'd3, 1'b1);
        issue(32'h80000000, 32'h4, 3'd4, 1'b1);
        issue(32'h80000000, 32'h4, 3'd5, 1'b1);
        issue(32'h12345678, 32'h0, 3'd4, 1'b1);
        issue(32'hF, 32'h5, 3'd6, 1'b1);
        issue(32'hA, 32'h5, 3'd7, 1'b1);
        issue(32'h7FFFFFFF, 32'h1, 3'd0, 1'b1);
        issue(32'hFFFFFFFF, 32'h1, 3'd0, 1'b1);
        issue(32'h80000000, 32'h1, 3'd1, 1'b1);
        drain();

        // Backpressure: the ADD is held on in_valid while the MUL sits in DONE
        bp_cnt = 5;
        issue(32'hA, 32'h3, 3'd2, 1'b1);
        issue(32'h1, 32'h2, 3'd0, 1'b1);
        drain();

        // Reset in the middle of a DIV discards it
        issue(32'hF, 32'h3, 3'd3, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        check("midrst_C", C, 32'h0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'h1);
        repeat (40) @(negedge clk);
        issue(32'h3, 32'h4, 3'd0, 1'b1);
        drain();

        rand_bp = 1'b1;
        for (int i = 0; i < 250; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            if (op == 3'd3 && $urandom_range(0, 7) == 0) b = 32'h0;
            issue(a, b, op, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        rand_bp = 1'b0;
        repeat (3) @(negedge clk);
        check("final_queue", q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
